// File: rtl/icache_pkg.sv
// Shared definitions for the direct-mapped instruction cache:
// FSM state encoding and PC index/tag extraction helpers.
package icache_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        MISS   = 2'd1,
        REFILL = 2'd2
    } state_t;

    localparam int WORD_W = 32;

    // Line index of a fetch address: pc[index_bits+1:2], zero-extended to 32 bits.
    function automatic logic [31:0] pc_index(input logic [31:0] pc, input int index_bits);
        return (pc >> 2) & ((32'd1 << index_bits) - 32'd1);
    endfunction

    // Tag of a fetch address: pc[31:index_bits+2], zero-extended to 32 bits.
    function automatic logic [31:0] pc_tag(input logic [31:0] pc, input int index_bits);
        return pc >> (index_bits + 2);
    endfunction

endpackage

// File: rtl/icache_tag_array.sv
// Valid/tag/data storage for the direct-mapped instruction cache.
// Combinational read port, single write port, global invalidate.
// Invalidate wins over a same-cycle write for the valid bit only; the
// tag and data are still written so the line simply stays invalid.
module icache_tag_array #(
    parameter int INDEX_BITS = 6,
    parameter int TAG_BITS   = 24
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [INDEX_BITS-1:0] rd_idx,
    output logic                  rd_valid,
    output logic [TAG_BITS-1:0]   rd_tag,
    output logic [31:0]           rd_data,
    input  logic                  wr_en,
    input  logic [INDEX_BITS-1:0] wr_idx,
    input  logic [TAG_BITS-1:0]   wr_tag,
    input  logic [31:0]           wr_data,
    input  logic                  inv
);

    localparam int LINES = 1 << INDEX_BITS;

    logic [LINES-1:0]    valid_r;
    logic [TAG_BITS-1:0] tag_r  [LINES];
    logic [31:0]         data_r [LINES];

    // Valid bits: cleared by reset or invalidate, set by a refill write.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_r <= {LINES{1'b0}};
        end else if (inv) begin
            valid_r <= {LINES{1'b0}};
        end else if (wr_en) begin
            valid_r[wr_idx] <= 1'b1;
        end
    end

    // Tag and data payload: written on refill, no reset needed.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            tag_r[wr_idx]  <= wr_tag;
            data_r[wr_idx] <= wr_data;
        end
    end

    assign rd_valid = valid_r[rd_idx];
    assign rd_tag   = tag_r[rd_idx];
    assign rd_data  = data_r[rd_idx];

endmodule

// File: rtl/icache_dm.sv
// Direct-mapped single-word-line instruction cache with a combinational hit
// path and a request/valid refill handshake.
// Optional hit/miss counters are enabled with the ICACHE_STATS_EN macro.
module icache_dm
    import icache_pkg::*;
#(
    parameter int INDEX_BITS = 6
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] pc_i,
    input  logic        req_i,
    input  logic        inv_i,
    output logic [31:0] instr_o,
    output logic        stall_o,
    output logic        mem_req_o,
    output logic [31:0] mem_addr_o,
    input  logic [31:0] mem_rdata_i,
    input  logic        mem_valid_i
`ifdef ICACHE_STATS_EN
    ,
    output logic [31:0] hit_cnt_o,
    output logic [31:0] miss_cnt_o
`endif
);

    localparam int TAG_BITS = 30 - INDEX_BITS;

    state_t state_r;
    state_t state_next_s;
    logic [31:0] miss_addr_r;

    logic [31:0] pc_idx_full_s, pc_tag_full_s, miss_idx_full_s, miss_tag_full_s;
    logic [INDEX_BITS-1:0] pc_idx_s, miss_idx_s;
    logic [TAG_BITS-1:0]   pc_tag_s, miss_tag_s;

    logic                rd_valid_s;
    logic [TAG_BITS-1:0] rd_tag_s;
    logic [31:0]         rd_data_s;
    logic                wr_en_s;
    logic                hit_s;
    logic                idle_miss_s;

    logic [31:0] instr_s;
    logic        stall_s;
    logic        mem_req_s;

    assign pc_idx_full_s   = pc_index(pc_i, INDEX_BITS);
    assign pc_tag_full_s   = pc_tag(pc_i, INDEX_BITS);
    assign miss_idx_full_s = pc_index(miss_addr_r, INDEX_BITS);
    assign miss_tag_full_s = pc_tag(miss_addr_r, INDEX_BITS);
    assign pc_idx_s        = pc_idx_full_s[INDEX_BITS-1:0];
    assign pc_tag_s        = pc_tag_full_s[TAG_BITS-1:0];
    assign miss_idx_s      = miss_idx_full_s[INDEX_BITS-1:0];
    assign miss_tag_s      = miss_tag_full_s[TAG_BITS-1:0];

    // Byte-offset bits and the zero upper bits of the helper results are not needed.
    logic unused_bits_s;
    assign unused_bits_s = ^{pc_i[1:0], miss_addr_r[1:0],
                             pc_idx_full_s[31:INDEX_BITS], pc_tag_full_s[31:TAG_BITS],
                             miss_idx_full_s[31:INDEX_BITS], miss_tag_full_s[31:TAG_BITS]};

    icache_tag_array #(
        .INDEX_BITS (INDEX_BITS),
        .TAG_BITS   (TAG_BITS)
    ) u_array (
        .clk      (clk),
        .rst      (rst),
        .rd_idx   (pc_idx_s),
        .rd_valid (rd_valid_s),
        .rd_tag   (rd_tag_s),
        .rd_data  (rd_data_s),
        .wr_en    (wr_en_s),
        .wr_idx   (miss_idx_s),
        .wr_tag   (miss_tag_s),
        .wr_data  (mem_rdata_i),
        .inv      (inv_i)
    );

    assign hit_s       = req_i && rd_valid_s && (rd_tag_s == pc_tag_s);
    assign idle_miss_s = (state_r == IDLE) && req_i && !hit_s;
    // Refill data is accepted only while waiting in MISS; stray pulses are dropped.
    assign wr_en_s     = (state_r == MISS) && mem_valid_i;

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Next-state logic: IDLE -> MISS on a lookup miss, MISS -> REFILL on data, REFILL -> IDLE.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            IDLE:    state_next_s = idle_miss_s ? MISS : IDLE;
            MISS:    state_next_s = mem_valid_i ? REFILL : MISS;
            REFILL:  state_next_s = IDLE;
            default: state_next_s = IDLE;
        endcase
    end

    // Output decode: hit data and stall for the core, refill request to memory.
    always_comb begin
        instr_s   = 32'd0;
        stall_s   = 1'b0;
        mem_req_s = 1'b0;
        case (state_r)
            IDLE: begin
                if (hit_s) begin
                    instr_s = rd_data_s;
                end else begin
                    stall_s = req_i;
                end
            end
            MISS: begin
                stall_s   = 1'b1;
                mem_req_s = 1'b1;
            end
            REFILL:  stall_s = 1'b1;
            default: stall_s = 1'b0;
        endcase
    end

    // Reset forces quiet outputs immediately, even with a fetch pending.
    assign instr_o    = rst ? 32'd0 : instr_s;
    assign stall_o    = rst ? 1'b0  : stall_s;
    assign mem_req_o  = rst ? 1'b0  : mem_req_s;
    assign mem_addr_o = {miss_addr_r[31:2], 2'b00};

    // Miss address capture; held for the whole refill regardless of pc_i.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            miss_addr_r <= 32'd0;
        end else if (idle_miss_s) begin
            miss_addr_r <= pc_i;
        end
    end

`ifdef ICACHE_STATS_EN
    logic [31:0] hit_cnt_r;
    logic [31:0] miss_cnt_r;

    // Saturating hit/miss counters; unaffected by invalidate.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hit_cnt_r  <= 32'd0;
            miss_cnt_r <= 32'd0;
        end else begin
            if ((state_r == IDLE) && hit_s && (hit_cnt_r != 32'hFFFF_FFFF)) begin
                hit_cnt_r <= hit_cnt_r + 32'd1;
            end
            if (idle_miss_s && (miss_cnt_r != 32'hFFFF_FFFF)) begin
                miss_cnt_r <= miss_cnt_r + 32'd1;
            end
        end
    end

    assign hit_cnt_o  = hit_cnt_r;
    assign miss_cnt_o = miss_cnt_r;
`endif

endmodule

// File: tb/tb_icache_dm.sv
// Directed, table-driven bench for icache_dm. Each table row is one clock
// cycle of inputs plus the expected combinational outputs for that cycle.
module tb_icache_dm;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] pc_i;
    logic        req_i;
    logic        inv_i;
    logic [31:0] instr_o;
    logic        stall_o;
    logic        mem_req_o;
    logic [31:0] mem_addr_o;
    logic [31:0] mem_rdata_i;
    logic        mem_valid_i;
`ifdef ICACHE_STATS_EN
    logic [31:0] hit_cnt;
    logic [31:0] miss_cnt;
`endif

    icache_dm #(.INDEX_BITS(6)) dut (
        .clk         (clk),
        .rst         (rst),
        .pc_i        (pc_i),
        .req_i       (req_i),
        .inv_i       (inv_i),
        .instr_o     (instr_o),
        .stall_o     (stall_o),
        .mem_req_o   (mem_req_o),
        .mem_addr_o  (mem_addr_o),
        .mem_rdata_i (mem_rdata_i),
        .mem_valid_i (mem_valid_i)
`ifdef ICACHE_STATS_EN
        ,
        .hit_cnt_o   (hit_cnt),
        .miss_cnt_o  (miss_cnt)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        req;
        logic [31:0] pc;
        logic        inv;
        logic        mv;
        logic [31:0] rdata;
        logic        e_stall;
        logic [31:0] e_instr;
        logic        e_mreq;
        logic [31:0] e_addr;
    } vec_t;

    vec_t vecs[$];
    int errors = 0;
    int checks = 0;
    int exp_hits = 0;
    int exp_misses = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic add_row(input logic req, input logic [31:0] pc, input logic inv,
                           input logic mv, input logic [31:0] rdata, input logic e_stall,
                           input logic [31:0] e_instr, input logic e_mreq, input logic [31:0] e_addr);
        vec_t v;
        v = '{req, pc, inv, mv, rdata, e_stall, e_instr, e_mreq, e_addr};
        vecs.push_back(v);
    endtask

    // Miss in IDLE, lat cycles in MISS (data on the last), then one REFILL cycle.
    task automatic add_miss(input logic [31:0] pc, input logic [31:0] data, input int lat,
                            input logic inv_on_valid);
        add_row(1'b1, pc, 1'b0, 1'b0, 32'd0, 1'b1, 32'd0, 1'b0, 32'd0);
        exp_misses++;
        for (int k = 1; k < lat; k++) begin
            add_row(1'b1, pc, 1'b0, 1'b0, 32'd0, 1'b1, 32'd0, 1'b1, pc);
        end
        add_row(1'b1, pc, inv_on_valid, 1'b1, data, 1'b1, 32'd0, 1'b1, pc);
        add_row(1'b1, pc, 1'b0, 1'b0, 32'd0, 1'b1, 32'd0, 1'b0, 32'd0);
    endtask

    task automatic add_hit(input logic [31:0] pc, input logic [31:0] data);
        add_row(1'b1, pc, 1'b0, 1'b0, 32'd0, 1'b0, data, 1'b0, 32'd0);
        exp_hits++;
    endtask

    task automatic add_fill(input logic [31:0] pc, input logic [31:0] data, input int lat);
        add_miss(pc, data, lat, 1'b0);
        add_hit(pc, data);
    endtask

    initial begin
        // Boot fetch: 3-cycle memory, then refetch hits.
        add_fill(32'hBFC0_0000, 32'h2408_0001, 3);
        add_hit(32'hBFC0_0000, 32'h2408_0001);
        add_row(1'b0, 32'hBFC0_0000, 1'b0, 1'b0, 32'd0, 1'b0, 32'd0, 1'b0, 32'd0);
        // Conflict at index 4.
        add_fill(32'h0000_0010, 32'hAAAA_0010, 1);
        add_fill(32'h0000_0110, 32'hBBBB_0110, 2);
        add_fill(32'h0000_0010, 32'hAAAA_1010, 1);
        // pc_i moves during MISS; refill stays on the captured address.
        add_row(1'b1, 32'h0000_0020, 1'b0, 1'b0, 32'd0, 1'b1, 32'd0, 1'b0, 32'd0);
        exp_misses++;
        add_row(1'b1, 32'h0000_0040, 1'b0, 1'b0, 32'd0, 1'b1, 32'd0, 1'b1, 32'h0000_0020);
        add_row(1'b1, 32'h0000_0040, 1'b0, 1'b1, 32'hCCCC_0020, 1'b1, 32'd0, 1'b1, 32'h0000_0020);
        add_row(1'b1, 32'h0000_0020, 1'b0, 1'b0, 32'd0, 1'b1, 32'd0, 1'b0, 32'd0);
        add_hit(32'h0000_0020, 32'hCCCC_0020);
        // Invalidate in IDLE: the hit still returns data, then every line misses.
        add_row(1'b1, 32'h0000_0020, 1'b1, 1'b0, 32'd0, 1'b0, 32'hCCCC_0020, 1'b0, 32'd0);
        exp_hits++;
        add_fill(32'h0000_0010, 32'hE000_0010, 1);
        add_fill(32'h0000_0020, 32'hE000_0020, 2);
        add_fill(32'hBFC0_0000, 32'hE0BF_C000, 1);
        // Invalidate together with refill data: the line re-misses.
        add_miss(32'h0000_0030, 32'hDDDD_0030, 2, 1'b1);
        add_fill(32'h0000_0030, 32'hDDDD_1030, 1);

        rst = 1'b1; req_i = 1'b1; pc_i = 32'hBFC0_0000; inv_i = 1'b0;
        mem_valid_i = 1'b0; mem_rdata_i = 32'd0;
        #1;
        check("reset_stall", {31'd0, stall_o}, 32'd0);
        check("reset_mem_req", {31'd0, mem_req_o}, 32'd0);
        check("reset_instr", instr_o, 32'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < vecs.size(); i++) begin
            if (i != 0) @(negedge clk);
            req_i = vecs[i].req; pc_i = vecs[i].pc; inv_i = vecs[i].inv;
            mem_valid_i = vecs[i].mv; mem_rdata_i = vecs[i].rdata;
            #1;
            check($sformatf("row%0d_stall", i), {31'd0, stall_o}, {31'd0, vecs[i].e_stall});
            check($sformatf("row%0d_mem_req", i), {31'd0, mem_req_o}, {31'd0, vecs[i].e_mreq});
            if (!vecs[i].e_stall) check($sformatf("row%0d_instr", i), instr_o, vecs[i].e_instr);
            if (vecs[i].e_mreq) check($sformatf("row%0d_mem_addr", i), mem_addr_o, vecs[i].e_addr);
        end

`ifdef ICACHE_STATS_EN
        @(negedge clk);
        req_i = 1'b0; inv_i = 1'b0; mem_valid_i = 1'b0;
        #1;
        check("hit_cnt", hit_cnt, 32'(exp_hits));
        check("miss_cnt", miss_cnt, 32'(exp_misses));
`endif

        // Reset while a refill is outstanding.
        @(negedge clk);
        req_i = 1'b1; pc_i = 32'h0000_0050; inv_i = 1'b0; mem_valid_i = 1'b0;
        #1;
        check("rst_seq_miss_stall", {31'd0, stall_o}, 32'd1);
        @(negedge clk);
        #1;
        check("rst_seq_mem_req", {31'd0, mem_req_o}, 32'd1);
        check("rst_seq_mem_addr", mem_addr_o, 32'h0000_0050);
        rst = 1'b1;
        #1;
        check("rst_seq_mem_req_drop", {31'd0, mem_req_o}, 32'd0);
        check("rst_seq_stall_drop", {31'd0, stall_o}, 32'd0);
`ifdef ICACHE_STATS_EN
        check("rst_seq_hit_cnt", hit_cnt, 32'd0);
        check("rst_seq_miss_cnt", miss_cnt, 32'd0);
`endif
        @(negedge clk);
        rst = 1'b0; req_i = 1'b0;
        @(negedge clk);
        mem_valid_i = 1'b1; mem_rdata_i = 32'hDEAD_BEEF;
        #1;
        check("late_valid_stall", {31'd0, stall_o}, 32'd0);
        check("late_valid_mem_req", {31'd0, mem_req_o}, 32'd0);
        @(negedge clk);
        mem_valid_i = 1'b0; req_i = 1'b1; pc_i = 32'h0000_0050;
        #1;
        check("post_rst_first_miss", {31'd0, stall_o}, 32'd1);
        @(negedge clk);
        #1;
        check("post_rst_mem_req", {31'd0, mem_req_o}, 32'd1);
        check("post_rst_mem_addr", mem_addr_o, 32'h0000_0050);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
